seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parameterised Mealy serial-pattern detector; successor to the fixed 3-state "010" detector.
- Pattern value, pattern length (2..SEQ_W) and overlap mode are runtime-loadable.
- Serial bits are qualified by a valid strobe.
- Outputs a combinational Mealy match, a registered copy, and optional match statistics; sits between the serial front end and the checker/scoreboard logic.

Parameters:
- SEQ_W, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(SEQ_W+1), width of the pattern-length field.
- CNT_W, 16, width of the match counter (optional feature).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  latch pattern/pat_len/overlap_en this cycle; restarts detection.
- pattern  in  SEQ_W  pattern; bit pat_len-1 is the first bit received, bit 0 the last.
- pat_len  in  LEN_W  active pattern length.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  seq_in is meaningful this cycle.
- seq_in  in  1  serial data bit.
- match  out  1  combinational Mealy match for the current bit.
- match_q  out  1  match registered one cycle later.
- state_o  out  2  current FSM state, for debug.
- match_cnt  out  CNT_W  saturating match count; only present with MATCH_CNT_EN.

Behaviour:
- Reset (rst_n=0, async) sets:
  - state S_IDLE; history, fill, cfg registers 0.
  - match_q=0; match_cnt=0.
  - match=0 while in reset.
- Config registers: cfg_pat, cfg_len, cfg_ovl.
  - Loaded on a cfg_load edge.
  - Length clamp: pat_len<2 stores 2; pat_len>SEQ_W stores SEQ_W.
- History register hist[SEQ_W-2:0]:
  - hist[0] is the newest bit.
  - On an accepted bit: hist <= {hist[SEQ_W-3:0], seq_in}.
- fill counter (LEN_W bits): number of valid history bits, saturating at cfg_len-1.
- Window: {hist[cfg_len-2:0], seq_in}, compared against cfg_pat[cfg_len-1:0]; bits above cfg_len are ignored.
- FSM states: S_IDLE, S_FILL, S_DETECT.
  - S_IDLE: no configuration yet; in_valid is ignored; match=0. cfg_load -> S_FILL.
  - S_FILL:
    - Each in_valid shifts a bit in and increments fill.
    - When fill becomes cfg_len-1 -> S_DETECT.
    - match=0.
  - S_DETECT:
    - match = in_valid & (window == pattern).
    - On a match with cfg_ovl=1: shift the bit in and stay in S_DETECT.
    - On a match with cfg_ovl=0: clear fill to 0, discard history, go to S_FILL. The matching bit is not reused.
    - No match: shift and stay in S_DETECT.
- in_valid=0 holds every register unchanged; match=0.
- cfg_load from any state:
  - Reload the config, clear hist/fill, go to S_FILL. match_cnt is untouched.
  - cfg_load takes priority over a simultaneous in_valid: the bit is discarded and match=0 that cycle.
- Latency: match is asserted in the same cycle as the last pattern bit; match_q follows exactly one cycle later.
- Example: cfg_len=2 → S_FILL needs 1 valid bit; detection is possible from the 2nd bit.
- Mid-stream reset: outputs return to reset values immediately (async). A fresh cfg_load is required afterwards.

Optional Feature:
- Macro MATCH_CNT_EN.
- Defined:
  - match_cnt port exists.
  - Increments by 1 on each cycle with match=1.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- Undefined: no match_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package pkg_seq_det:
  - typedef enum logic [1:0] det_state_t {S_IDLE, S_FILL, S_DETECT}.
  - Constant MIN_LEN=2.
  - Function clamp_len.
- No sub-module required. All logic lives in a single module: FSM, shift register and comparator.

Test Plan:
- Reset: rst_n=0 mid-stream → state_o=S_IDLE, match=0, match_q=0, match_cnt=0 immediately. After release, in_valid bits without cfg_load → no match.
- Overlap: cfg pattern=3'b010, len=3, ovl=1; bits 0,1,0,1,0 → match on bits 3 and 5; match_q on the following cycles; match_cnt=2.
- Non-overlap: same config with ovl=0, same bits → match on bit 3 only; match_cnt=1.
- Length 4 with gaps: pattern=4'b1011, len=4, ovl=1; stream 1,0,1,1,0,1,1 with in_valid=0 gaps inserted → match on bits 4 and 7 only; no match during gaps.
- Clamp and priority:
  - pat_len=0 → behaves as length 2; pattern 2'b11 with stream 1,1,1 → matches on bits 2 and 3.
  - cfg_load concurrent with a valid bit → that bit is ignored and match=0.
- Saturation (CNT_W=2, MATCH_CNT_EN): 5 matches → match_cnt stays at 3.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// pkg_seq_det: shared types and helpers for the parameterised serial
// pattern detector.
//   det_state_t : FSM state encoding (S_IDLE, S_FILL, S_DETECT)
//   MIN_LEN     : shortest supported pattern length
//   clamp_len   : limits a requested pattern length to MIN_LEN..max_len
package pkg_seq_det;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DETECT = 2'd2
    } det_state_t;

    localparam int unsigned MIN_LEN = 2;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len < MIN_LEN) begin
            return MIN_LEN;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_detector_param.sv
// seq_detector_param: parameterised Mealy serial-pattern detector with a
// runtime-loadable pattern, pattern length and overlap mode.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   cfg_load   - latch pattern/pat_len/overlap_en, restart detection
//   pattern    - pattern, bit pat_len-1 is received first, bit 0 last
//   pat_len    - active pattern length (clamped to 2..SEQ_W)
//   overlap_en - 1 = overlapping detection, 0 = non-overlapping
//   in_valid   - seq_in is meaningful this cycle
//   seq_in     - serial data bit
//   match      - combinational Mealy match for the current bit
//   match_q    - match delayed by one cycle
//   state_o    - current FSM state (debug)
//   match_cnt  - saturating match count (only with MATCH_CNT_EN defined)
//
// Build option: define MATCH_CNT_EN to add the match_cnt port and counter.
module seq_detector_param
    import pkg_seq_det::*;
#(
    parameter int SEQ_W = 8,
    parameter int LEN_W = $clog2(SEQ_W + 1),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [SEQ_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             in_valid,
    input  logic             seq_in,
    output logic             match,
    output logic             match_q,
    output logic [1:0]       state_o
`ifdef MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    det_state_t       state, state_nx;
    logic [SEQ_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic [SEQ_W-2:0] hist, hist_nx;
    logic [LEN_W-1:0] fill, fill_nx;

    logic [SEQ_W-1:0] window;
    logic [SEQ_W-1:0] len_mask;
    logic [SEQ_W-2:0] hist_shift;
    logic             win_eq;

    // Full-width window; bits at or above cfg_len are masked out of the
    // comparison instead of using a variable-width slice.
    assign window     = {hist, seq_in};
    assign hist_shift = window[SEQ_W-2:0];

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < SEQ_W; i++) begin
            len_mask[i] = (i < cfg_len);
        end
    end

    assign win_eq  = (((window ^ cfg_pat) & len_mask) == '0);
    assign state_o = state;

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill;
        match    = 1'b0;
        if (cfg_load) begin
            // Reload wins over a concurrent valid bit, which is dropped.
            state_nx = S_FILL;
            hist_nx  = '0;
            fill_nx  = '0;
        end else if (in_valid) begin
            case (state)
                S_IDLE: begin
                end
                S_FILL: begin
                    hist_nx = hist_shift;
                    fill_nx = fill + 1'b1;
                    if (fill_nx == LEN_W'(cfg_len - 1'b1)) begin
                        state_nx = S_DETECT;
                    end
                end
                S_DETECT: begin
                    match = win_eq;
                    if (win_eq && !cfg_ovl) begin
                        // Non-overlapping: the matching bit is not reused.
                        state_nx = S_FILL;
                        hist_nx  = '0;
                        fill_nx  = '0;
                    end else begin
                        hist_nx = hist_shift;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            hist    <= '0;
            fill    <= '0;
            match_q <= 1'b0;
        end else begin
            state   <= state_nx;
            hist    <= hist_nx;
            fill    <= fill_nx;
            match_q <= match;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b0;
        end else if (cfg_load) begin
            cfg_pat <= pattern;
            cfg_len <= LEN_W'(clamp_len(32'(pat_len), SEQ_W));
            cfg_ovl <= overlap_en;
        end
    end

`ifdef MATCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: self-checking bench for seq_detector_param.
// Expected match values are pushed to a scoreboard queue as each bit is
// driven and popped when the DUT output is sampled; match_q and (with
// MATCH_CNT_EN) a saturating count are checked after every edge.
module tb_seq_detector_param;
    import pkg_seq_det::*;

    localparam int SEQ_W = 8;
    localparam int LEN_W = $clog2(SEQ_W + 1);
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             cfg_load;
    logic [SEQ_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap_en;
    logic             in_valid;
    logic             seq_in;
    logic             match;
    logic             match_q;
    logic [1:0]       state_o;
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        exp_q[$];
    logic        last_exp;
    int unsigned exp_cnt = 0;

    seq_detector_param #(
        .SEQ_W(SEQ_W),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_load   (cfg_load),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .overlap_en (overlap_en),
        .in_valid   (in_valid),
        .seq_in     (seq_in),
        .match      (match),
        .match_q    (match_q),
        .state_o    (state_o)
`ifdef MATCH_CNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input string tag, input logic cl, input logic v,
                        input logic b, input logic exp);
        logic e;
        cfg_load = cl;
        in_valid = v;
        seq_in   = b;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " match"}, {31'd0, match}, {31'd0, e});
        last_exp = e;
        if (e && exp_cnt < (2 ** CNT_W) - 1) exp_cnt++;
        @(posedge clk);
        #1;
        chk({tag, " match_q"}, {31'd0, match_q}, {31'd0, last_exp});
`ifdef MATCH_CNT_EN
        chk({tag, " match_cnt"}, {30'd0, match_cnt}, exp_cnt);
`endif
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [SEQ_W-1:0] p,
                        input logic [LEN_W-1:0] l, input logic o);
        pattern    = p;
        pat_len    = l;
        overlap_en = o;
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, " state"}, {30'd0, state_o}, {30'd0, S_FILL});
    endtask

    // Drives a bit vector MSB-first, all valid, with a matching expect vector.
    task automatic stream(input string tag, input int n,
                          input logic [15:0] bits, input logic [15:0] exps);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, 1'b0, 1'b1, bits[i], exps[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; pattern = '0; pat_len = '0;
        overlap_en = 1'b0; in_valid = 1'b0; seq_in = 1'b0;
        #12;
        chk("rst state", {30'd0, state_o}, {30'd0, S_IDLE});
        chk("rst match", {31'd0, match}, 32'd0);
        chk("rst match_q", {31'd0, match_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No configuration: valid bits are ignored.
        stream("nocfg", 3, 16'b101, 16'b000);
        chk("nocfg state", {30'd0, state_o}, {30'd0, S_IDLE});

        // Overlapping 010.
        load("ovl cfg", 8'b010, 4'd3, 1'b1);
        stream("ovl", 5, 16'b01010, 16'b00101);

        // Non-overlapping 010: the second candidate reuses a consumed bit.
        load("novl cfg", 8'b010, 4'd3, 1'b0);
        stream("novl", 5, 16'b01010, 16'b00100);

        // Length 4, pattern 1011 with junk in the upper bits, gaps included.
        load("len4 cfg", 8'hFB, 4'd4, 1'b1);
        stream("len4", 2, 16'b10, 16'b00);
        step("len4 gap", 1'b0, 1'b0, 1'b1, 1'b0);
        stream("len4", 2, 16'b11, 16'b01);
        step("len4 gap", 1'b0, 1'b0, 1'b1, 1'b0);
        stream("len4", 2, 16'b01, 16'b00);
        step("len4 gap", 1'b0, 1'b0, 1'b1, 1'b0);
        stream("len4", 1, 16'b1, 16'b1);

        // pat_len=0 clamps to 2.
        load("clamp2 cfg", 8'h03, 4'd0, 1'b1);
        stream("clamp2", 3, 16'b111, 16'b011);

        // pat_len beyond SEQ_W clamps to 8.
        load("clamp8 cfg", 8'hA5, 4'd15, 1'b1);
        stream("clamp8", 10, 16'b1110100101, 16'b0000000001);

        // cfg_load beats a concurrent valid bit.
        load("prio cfg", 8'h03, 4'd2, 1'b1);
        stream("prio", 1, 16'b1, 16'b0);
        pattern = 8'h03; pat_len = 4'd2; overlap_en = 1'b1;
        step("prio load+bit", 1'b1, 1'b1, 1'b1, 1'b0);
        stream("prio", 2, 16'b11, 16'b01);

        // Mid-stream asynchronous reset while a match is pending.
        in_valid = 1'b1;
        seq_in   = 1'b1;
        #1;
        chk("pre-rst match", {31'd0, match}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst state", {30'd0, state_o}, {30'd0, S_IDLE});
        chk("midrst match", {31'd0, match}, 32'd0);
        chk("midrst match_q", {31'd0, match_q}, 32'd0);
`ifdef MATCH_CNT_EN
        chk("midrst match_cnt", {30'd0, match_cnt}, 32'd0);
`endif
        exp_cnt  = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stream("postrst", 3, 16'b111, 16'b000);
        chk("postrst state", {30'd0, state_o}, {30'd0, S_IDLE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
